ddr2_preload_packer: RTL and testbench
======================================

# ddr2_preload_packer

Synthesizable, parametrised preload engine for the DDR2 memory subsystem. It takes a stream of DATA_W-bit program words, packs WORDS of them into one DDR burst beat with per-byte valid mask, and generates the matching bank/row/column address. Partial final beats are flushed with a correct mask. Its output drives the memory-model or controller write path in place of simulator-only loading.

## Interface
- DATA_W, 32: input word width; multiple of DQ_W and of 8
- WORDS, 4: input words per output beat; power of 2, ≥2
- DQ_W, 16: DRAM data-bus width; COL_STEP = DATA_W/DQ_W columns per word
- BANK_BITS, 3: bank address width
- ROW_BITS, 13: row address width
- COL_BITS, 10: column address width; ADDR_W = BANK_BITS+ROW_BITS+COL_BITS
- ck  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; latch base_addr, begin new load, aborts any load in progress
- base_addr  in  ADDR_W  flat column address {bank,row,col}; low log2(WORDS*COL_STEP) bits ignored (treated 0)
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  DATA_W  input word
- in_last  in  1  qualifies final word of load
- out_valid  out  1  beat valid
- out_ready  in  1  beat consumed when out_valid & out_ready
- out_data  out  DATA_W*WORDS  packed beat; word k at [k*DATA_W +: DATA_W]
- out_mask  out  DATA_W*WORDS/8  1 = byte valid
- out_bank  out  BANK_BITS  beat bank
- out_row  out  ROW_BITS  beat row
- out_col  out  COL_BITS  beat first column
- done  out  1  one-cycle pulse after final beat handshake
- wrap_err  out  1  sticky: address wrapped past top of space
- beat_cnt  out  32  beats emitted since last start

## Operation
- States: IDLE, ACCUM, EMIT.
- IDLE: in_ready=0, out_valid=0. start → ACCUM; addr←aligned base_addr, idx←0, data/mask←0, beat_cnt←0, wrap_err←0, last_seen←0.
- ACCUM: in_ready=1. On accept: lane idx←in_data, lane idx mask bytes←1. If idx==WORDS-1 or in_last → EMIT (last_seen←in_last); else idx←idx+1.
- EMIT: in_ready=0, out_valid=1; out_data/mask/bank/row/col stable until handshake. {out_bank,out_row,out_col}=addr (address of lane 0).
- EMIT handshake: beat_cnt+1. If last_seen → IDLE, done=1 next cycle. Else → ACCUM, idx←0, data/mask←0, addr←addr+WORDS*COL_STEP mod 2^ADDR_W; if that addition carries out, wrap_err←1.
- Unfilled lanes of a partial beat: data 0, mask 0.
- start in ACCUM or EMIT: partial beat discarded, out_valid drops next cycle, restart as from IDLE. start has priority over a same-cycle input or output handshake (that handshake is ignored, beat_cnt not incremented).
- in_valid in IDLE ignored. in_last with idx==0 emits a one-lane beat.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE; in_ready, out_valid, done, wrap_err = 0; out_data, out_mask, out_bank, out_row, out_col, beat_cnt = 0.
- in_ready=1 the cycle after start.
- out_valid rises the cycle after acceptance of the beat-completing word.
- Throughput: WORDS accepted cycles plus one EMIT cycle per beat with out_ready=1 (one bubble per beat).
- done asserts the cycle after final handshake, for exactly one cycle.
- All outputs registered; no combinational in→out path except none (in_ready, out_valid from state only).

## Test plan
- Defaults, base 0, words 0x11111111,0x22222222,0x33333333,0x44444444 (last on 4th), out_ready=1 → one beat data 0x44444444_33333333_22222222_11111111, mask 0xFFFF, bank 0 row 0 col 0, done one cycle later, beat_cnt=1.
- Base 0x0000010 (low bits 0x7 set in a second run → same result), 6 words last on 6th → beat0 col 0x010 mask 0xFFFF; beat1 col 0x018 mask 0x00FF, upper 64 bits 0; beat_cnt=2.
- Hold out_ready=0 five cycles in EMIT with in_valid=1 → in_ready=0, out_* unchanged, no input consumed; release → next word lands in lane 0 of new beat.
- Base 0x3FFFFF8 (bank 7, row 0x1FFF, col 0x3F8), 8 words → beat0 at 0x3FFFFF8, beat1 bank 0 row 0 col 0, wrap_err=1 until next start.
- start pulse after 2 words accepted → no beat emitted, beat_cnt=0, new load from new base proceeds normally.
- rst_n low for 1 cycle mid-EMIT → all outputs 0 immediately, state IDLE, in_valid ignored until start.

Source files
------------

// File: rtl/ddr2_preload_packer.sv
// Preload engine: packs WORDS program words into one DDR burst beat with a byte mask and
// walks the {bank,row,col} address of each beat from an aligned base.
module ddr2_preload_packer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned WORDS     = 4,
  parameter int unsigned DQ_W      = 16,
  parameter int unsigned BANK_BITS = 3,
  parameter int unsigned ROW_BITS  = 13,
  parameter int unsigned COL_BITS  = 10,
  localparam int unsigned ADDR_W   = BANK_BITS + ROW_BITS + COL_BITS,
  localparam int unsigned BEAT_W   = DATA_W * WORDS,
  localparam int unsigned MASK_W   = DATA_W * WORDS / 8
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BEAT_W-1:0]    out_data,
  output logic [MASK_W-1:0]    out_mask,
  output logic [BANK_BITS-1:0] out_bank,
  output logic [ROW_BITS-1:0]  out_row,
  output logic [COL_BITS-1:0]  out_col,
  output logic                 done,
  output logic                 wrap_err,
  output logic [31:0]          beat_cnt
);

  localparam int unsigned COL_STEP   = DATA_W / DQ_W;
  localparam int unsigned STEP       = WORDS * COL_STEP;
  localparam int unsigned ALIGN_BITS = $clog2(STEP);
  localparam int unsigned IDX_W      = $clog2(WORDS);
  localparam int unsigned MB         = DATA_W / 8;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN_BITS) - 1);
  localparam logic [ADDR_W:0]   STEP_EXT   = (ADDR_W + 1)'(STEP);
  localparam logic [IDX_W-1:0]  IDX_MAX    = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BEAT_W-1:0]   data_q, data_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [31:0]         beat_cnt_q, beat_cnt_d;
  logic                wrap_q, wrap_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W:0]     addr_sum;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    data_d      = data_q;
    mask_d      = mask_q;
    beat_cnt_d  = beat_cnt_q;
    wrap_d      = wrap_q;
    last_d      = last_q;
    done_d      = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    addr_sum    = {1'b0, addr_q} + STEP_EXT;

    // start wins over any same-cycle handshake, including mid-beat aborts.
    if (start) begin
      state_d     = StAccum;
      addr_d      = base_addr & ~ALIGN_MASK;
      idx_d       = '0;
      data_d      = '0;
      mask_d      = '0;
      beat_cnt_d  = '0;
      wrap_d      = 1'b0;
      last_d      = 1'b0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StAccum: begin
          if (in_valid && in_ready_q) begin
            data_d[int'(idx_q) * DATA_W +: DATA_W] = in_data;
            mask_d[int'(idx_q) * MB +: MB]         = '1;
            if (idx_q == IDX_MAX || in_last) begin
              state_d     = StEmit;
              last_d      = in_last;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        StEmit: begin
          if (out_ready) begin
            beat_cnt_d  = beat_cnt_q + 32'd1;
            out_valid_d = 1'b0;
            if (last_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d    = StAccum;
              in_ready_d = 1'b1;
              idx_d      = '0;
              data_d     = '0;
              mask_d     = '0;
              addr_d     = addr_sum[ADDR_W-1:0];
              wrap_d     = wrap_q | addr_sum[ADDR_W];
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      beat_cnt_q  <= '0;
      wrap_q      <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      beat_cnt_q  <= beat_cnt_d;
      wrap_q      <= wrap_d;
      last_q      <= last_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready                     = in_ready_q;
  assign out_valid                    = out_valid_q;
  assign out_data                     = data_q;
  assign out_mask                     = mask_q;
  assign {out_bank, out_row, out_col} = addr_q;
  assign done                         = done_q;
  assign wrap_err                     = wrap_q;
  assign beat_cnt                     = beat_cnt_q;

endmodule

// File: tb/tb_ddr2_preload_packer.sv
// Directed bench for ddr2_preload_packer at default parameters; beats are captured by a
// handshake monitor and compared against hand-computed values.
module tb_ddr2_preload_packer;

  logic         ck;
  logic         rst_n;
  logic         start;
  logic [25:0]  base_addr;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [15:0]  out_mask;
  logic [2:0]   out_bank;
  logic [12:0]  out_row;
  logic [9:0]   out_col;
  logic         done;
  logic         wrap_err;
  logic [31:0]  beat_cnt;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  mask;
    logic [2:0]   bank;
    logic [12:0]  row;
    logic [9:0]   col;
  } beat_t;

  beat_t beats[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  ddr2_preload_packer dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_bank  (out_bank),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done),
    .wrap_err  (wrap_err),
    .beat_cnt  (beat_cnt)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // A beat is consumed at the next rising edge when valid & ready hold and start is low.
  always @(negedge ck) begin
    beat_t b;
    if (rst_n && out_valid && out_ready && !start) begin
      b = '{data: out_data, mask: out_mask, bank: out_bank, row: out_row, col: out_col};
      beats.push_back(b);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic do_start(input logic [25:0] b);
    beats.delete();
    start     = 1'b1;
    base_addr = b;
    step();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      step();
    end
    check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", got, 1);
    step();
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_beat(input int i, input logic [127:0] d, input logic [15:0] m,
                            input logic [2:0] b, input logic [12:0] r, input logic [9:0] c);
    if (beats.size() <= i) begin
      check("beat_present", beats.size(), i + 1);
    end else begin
      check("beat_data", beats[i].data, d);
      check("beat_mask", beats[i].mask, m);
      check("beat_bank", beats[i].bank, b);
      check("beat_row", beats[i].row, r);
      check("beat_col", beats[i].col, c);
    end
  endtask

  initial begin
    logic [31:0] w6 [6];
    w6 = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, 32'hE4E4E4E4, 32'hF5F5F5F5};

    rst_n     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single full beat from base 0.
    do_start(26'h0);
    check("s1_in_ready_after_start", in_ready, 1);
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    send_word(32'h33333333, 1'b0);
    send_word(32'h44444444, 1'b1);
    check("s1_out_valid_rise", out_valid, 1);
    check("s1_in_ready_emit", in_ready, 0);
    wait_done();
    check("s1_nbeats", beats.size(), 1);
    check_beat(0, 128'h44444444_33333333_22222222_11111111, 16'hFFFF, 3'd0, 13'd0, 10'h000);
    check("s1_beat_cnt", beat_cnt, 1);

    // Six words, partial final beat; second run with low base bits set.
    for (int r = 0; r < 2; r++) begin
      do_start((r == 0) ? 26'h10 : 26'h17);
      for (int k = 0; k < 6; k++) send_word(w6[k], k == 5);
      wait_done();
      check("s2_nbeats", beats.size(), 2);
      check_beat(0, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 16'hFFFF, 3'd0, 13'd0, 10'h010);
      check_beat(1, 128'h00000000_00000000_F5F5F5F5_E4E4E4E4, 16'h00FF, 3'd0, 13'd0, 10'h018);
      check("s2_beat_cnt", beat_cnt, 2);
    end

    // Backpressure in EMIT while an input word is offered.
    do_start(26'h0);
    out_ready = 1'b0;
    send_word(32'h0000000A, 1'b0);
    send_word(32'h0000000B, 1'b0);
    send_word(32'h0000000C, 1'b0);
    send_word(32'h0000000D, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h0000000E;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("s3_stall_out_valid", out_valid, 1);
      check("s3_stall_in_ready", in_ready, 0);
      check("s3_stall_data", out_data, 128'h0000000D_0000000C_0000000B_0000000A);
      check("s3_stall_col", out_col, 10'h000);
      step();
    end
    out_ready = 1'b1;
    send_word(32'h0000000E, 1'b1);
    wait_done();
    check("s3_nbeats", beats.size(), 2);
    check_beat(0, 128'h0000000D_0000000C_0000000B_0000000A, 16'hFFFF, 3'd0, 13'd0, 10'h000);
    check_beat(1, 128'h00000000_00000000_00000000_0000000E, 16'h000F, 3'd0, 13'd0, 10'h008);

    // Address wrap past the top of the space.
    do_start(26'h3FFFFF8);
    check("s4_wrap_clear", wrap_err, 0);
    for (int k = 0; k < 8; k++) send_word(32'(k + 1), k == 7);
    wait_done();
    check("s4_nbeats", beats.size(), 2);
    check_beat(0, 128'h00000004_00000003_00000002_00000001, 16'hFFFF, 3'd7, 13'h1FFF, 10'h3F8);
    check_beat(1, 128'h00000008_00000007_00000006_00000005, 16'hFFFF, 3'd0, 13'h0000, 10'h000);
    check("s4_wrap_set", wrap_err, 1);
    step();
    check("s4_wrap_sticky", wrap_err, 1);
    do_start(26'h0);
    check("s4_wrap_cleared_by_start", wrap_err, 0);

    // Abort after two words, then a clean load from a new base.
    do_start(26'h100);
    send_word(32'h55555555, 1'b0);
    send_word(32'h66666666, 1'b0);
    do_start(26'h200);
    check("s5_beat_cnt_reset", beat_cnt, 0);
    check("s5_in_ready", in_ready, 1);
    send_word(32'h01010101, 1'b0);
    send_word(32'h02020202, 1'b0);
    send_word(32'h03030303, 1'b0);
    send_word(32'h04040404, 1'b1);
    wait_done();
    check("s5_nbeats", beats.size(), 1);
    check_beat(0, 128'h04040404_03030303_02020202_01010101, 16'hFFFF, 3'd0, 13'd0, 10'h200);
    check("s5_beat_cnt", beat_cnt, 1);

    // Asynchronous reset while a beat is stalled in EMIT.
    do_start(26'h3FFFFF8);
    for (int k = 0; k < 4; k++) send_word(32'hC0 + 32'(k), 1'b0);
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(32'hD0 + 32'(k), 1'b0);
    check("s6_pre_out_valid", out_valid, 1);
    check("s6_pre_beat_cnt", beat_cnt, 1);
    check("s6_pre_wrap", wrap_err, 1);
    rst_n = 1'b0;
    #1;
    check("s6_rst_out_valid", out_valid, 0);
    check("s6_rst_out_data", out_data, 0);
    check("s6_rst_out_mask", out_mask, 0);
    check("s6_rst_addr", {out_bank, out_row, out_col}, 0);
    check("s6_rst_wrap", wrap_err, 0);
    check("s6_rst_beat_cnt", beat_cnt, 0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("s6_idle_in_ready", in_ready, 0);
      check("s6_idle_out_valid", out_valid, 0);
      check("s6_idle_mask", out_mask, 0);
      check("s6_idle_done", done, 0);
    end
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
